// File: rtl/dev_dma_copy.sv
// PICO16a bus-initiator block copy engine: RD/CAP/WR per word under a req/gnt handshake.
// Optional fill mode (constant data to successive addresses) enabled by DMA_FILL_EN.
module dev_dma_copy #(
    parameter int LEN_W = 13
) (
    input  logic             cpu_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      src_adrs,
    input  logic [15:0]      dst_adrs,
    input  logic [LEN_W-1:0] len,
`ifdef DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [15:0]      fill_data,
`endif
    output logic             busy,
    output logic             done,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [15:0]      adrs,
    output logic             we,
    output logic [15:0]      to_dev,
    input  logic [15:0]      from_dev
);

    typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR, FIN} state_t;

    state_t           state, state_n;
    logic [15:0]      src, src_n, dst, dst_n, data, data_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             fill;
    logic [15:0]      fdata;

    logic             busy_n, req_n, done_n, we_n;
    logic [15:0]      adrs_n, to_dev_n;

`ifdef DMA_FILL_EN
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            fill  <= 1'b0;
            fdata <= 16'h0000;
        end else if (state == IDLE && start) begin
            fill  <= fill_mode;
            fdata <= fill_data;
        end
    end
`else
    assign fill  = 1'b0;
    assign fdata = 16'h0000;
`endif

    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        cnt_n   = cnt;
        data_n  = data;
        unique case (state)
            IDLE: begin
                if (start) begin
                    src_n   = src_adrs;
                    dst_n   = dst_adrs;
                    cnt_n   = len;
                    state_n = (len != '0) ? REQ : FIN;
                end
            end
            REQ: begin
                if (bus_gnt) state_n = fill ? WR : RD;
            end
            RD:  state_n = CAP;
            CAP: begin
                data_n  = from_dev;
                state_n = WR;
            end
            WR: begin
                src_n = src + 16'd1;
                dst_n = dst + 16'd1;
                cnt_n = cnt - 1'b1;
                // Grant is re-examined only here; a word in flight always finishes.
                if (cnt_n == '0)  state_n = FIN;
                else if (bus_gnt) state_n = fill ? WR : RD;
                else              state_n = REQ;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered images of the state being entered.
    always_comb begin
        busy_n   = 1'b0;
        req_n    = 1'b0;
        done_n   = 1'b0;
        we_n     = 1'b0;
        adrs_n   = 16'h0000;
        to_dev_n = 16'h0000;
        case (state_n)
            REQ: begin
                busy_n = 1'b1;
                req_n  = 1'b1;
            end
            RD, CAP: begin
                busy_n = 1'b1;
                req_n  = 1'b1;
                adrs_n = src_n;
            end
            WR: begin
                busy_n   = 1'b1;
                req_n    = 1'b1;
                we_n     = 1'b1;
                adrs_n   = dst_n;
                to_dev_n = fill ? fdata : data_n;
            end
            FIN:     done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            src     <= 16'h0000;
            dst     <= 16'h0000;
            cnt     <= '0;
            data    <= 16'h0000;
            busy    <= 1'b0;
            bus_req <= 1'b0;
            done    <= 1'b0;
            we      <= 1'b0;
            adrs    <= 16'h0000;
            to_dev  <= 16'h0000;
        end else begin
            state   <= state_n;
            src     <= src_n;
            dst     <= dst_n;
            cnt     <= cnt_n;
            data    <= data_n;
            busy    <= busy_n;
            bus_req <= req_n;
            done    <= done_n;
            we      <= we_n;
            adrs    <= adrs_n;
            to_dev  <= to_dev_n;
        end
    end

endmodule
